// File: rtl/pc_unit.sv
// pc_unit: fetch-stage successor PC generator with halt/resume, trap vector and return-address stack.
module pc_unit #(
    parameter int PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = 'h80,
    parameter int INSTR_BYTES = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pc,
    output logic                pc_valid,
    input  logic                pc_ready,
    input  logic                stall,
    input  logic                halt,
    input  logic                resume,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                trap_valid,
    input  logic                ras_push,
    input  logic [PC_WIDTH-1:0] ras_push_addr,
    input  logic                ras_pop,
    output logic                misalign_err,
    output logic                ras_underflow,
    output logic                ras_empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PC_WIDTH-1:0] AMASK = PC_WIDTH'(INSTR_BYTES - 1);
    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INSTR_BYTES);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
    state_t state, state_nxt;

    logic [PC_WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]       top, top_inc;
    logic [CW-1:0]       cnt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic                fire, wrong_path, do_push, do_pop, full;

    assign pc_valid   = state == RUN;
    assign fire       = pc_valid & pc_ready & ~stall;
    assign ras_empty  = cnt == '0;
    assign full       = cnt == CW'(RAS_DEPTH);
    assign top_inc    = top + 1'b1;
    // Redirect or trap in the same cycle means decode is on the wrong path.
    assign wrong_path = trap_valid | redirect_valid;
    assign do_push    = fire & ras_push & ~wrong_path;
    assign do_pop     = fire & ras_pop & ~wrong_path & ~ras_empty;

    always_comb begin
        state_nxt = trap_valid ? RUN :
                    state == BOOT ? RUN :
                    (state == RUN && halt) ? HALTED :
                    (state == HALTED && resume) ? RUN : state;
        pc_nxt = trap_valid ? TRAP_VECTOR :
                 redirect_valid ? (redirect_target & ~AMASK) :
                 do_pop ? ras[top] :
                 fire ? pc + STEP : pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc            <= RESET_VECTOR;
            top           <= '0;
            cnt           <= '0;
            misalign_err  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            misalign_err  <= redirect_valid & ~trap_valid & |(redirect_target & AMASK);
            ras_underflow <= fire & ras_pop & ras_empty & ~wrong_path;
            if (trap_valid) begin
                top <= '0;
                cnt <= '0;
            end else if (do_push && !do_pop) begin
                top <= top_inc;
                cnt <= full ? cnt : cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                top <= top - 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Push+pop replaces the top entry in place; a lone push writes above the top.
    always_ff @(posedge clk) begin
        if (!rst && do_push)
            ras[do_pop ? top : top_inc] <= ras_push_addr;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit; expected per-cycle outputs are queued at drive time.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst, pc_ready, stall, halt, resume, redirect_valid, trap_valid, ras_push, ras_pop;
    logic [31:0] redirect_target, ras_push_addr, pc;
    logic        pc_valid, misalign_err, ras_underflow, ras_empty;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid, mis, und, emp;
    } exp_t;
    exp_t q[$];
    int total = 0, bad = 0;

    pc_unit dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .stall(stall), .halt(halt), .resume(resume), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .trap_valid(trap_valid), .ras_push(ras_push),
        .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .misalign_err(misalign_err),
        .ras_underflow(ras_underflow), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, ".pc"}, pc, e.pc);
            check({e.tag, ".valid"}, 32'(pc_valid), 32'(e.valid));
            check({e.tag, ".mis"}, 32'(misalign_err), 32'(e.mis));
            check({e.tag, ".und"}, 32'(ras_underflow), 32'(e.und));
            check({e.tag, ".emp"}, 32'(ras_empty), 32'(e.emp));
        end
    end

    task automatic tick(input string tag, input logic [31:0] epc, input logic ev,
                        input logic em = 1'b0, input logic eu = 1'b0, input logic ee = 1'b1);
        exp_t e;
        e.tag = tag; e.pc = epc; e.valid = ev; e.mis = em; e.und = eu; e.emp = ee;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; pc_ready = 1; stall = 0; halt = 0; resume = 0; redirect_valid = 0;
        trap_valid = 0; ras_push = 0; ras_pop = 0; redirect_target = '0; ras_push_addr = '0;
        tick("rst", 32'h0, 0);
        rst = 0;
        tick("boot", 32'h0, 1);
        for (int i = 1; i <= 4; i++) tick("seq", 32'(4 * i), 1);
        stall = 1;
        for (int i = 0; i < 3; i++) tick("stall", 32'h10, 1);
        stall = 0; pc_ready = 0;
        for (int i = 0; i < 3; i++) tick("notready", 32'h10, 1);
        stall = 1; pc_ready = 1; redirect_valid = 1; redirect_target = 32'h40;
        tick("stall_redir", 32'h40, 1);
        stall = 0; redirect_target = 32'h42;
        tick("misalign", 32'h40, 1, 1);
        redirect_valid = 0;
        tick("mis_pulse", 32'h44, 1);
        redirect_valid = 1; trap_valid = 1;
        tick("trap_redir", 32'h80, 1);
        redirect_valid = 0; trap_valid = 0;
        tick("after_trap", 32'h84, 1);
        ras_push = 1;
        for (int i = 1; i <= 5; i++) begin
            ras_push_addr = 32'(i * 'h100);
            tick("push", 32'(32'h84 + 4 * i), 1, 0, 0, 0);
        end
        ras_push = 0; ras_pop = 1;
        tick("pop1", 32'h500, 1, 0, 0, 0);
        tick("pop2", 32'h400, 1, 0, 0, 0);
        tick("pop3", 32'h300, 1, 0, 0, 0);
        tick("pop4", 32'h200, 1, 0, 0, 1);
        tick("pop5", 32'h204, 1, 0, 1, 1);
        ras_pop = 0;
        tick("und_pulse", 32'h208, 1);
        ras_push = 1; ras_push_addr = 32'h600;
        tick("push6", 32'h20C, 1, 0, 0, 0);
        ras_pop = 1; ras_push_addr = 32'h700;
        tick("pushpop", 32'h600, 1, 0, 0, 0);
        ras_push = 0;
        tick("pop_repl", 32'h700, 1, 0, 0, 1);
        ras_pop = 0; redirect_valid = 1; redirect_target = 32'h20;
        tick("to20", 32'h20, 1);
        redirect_valid = 0; halt = 1; stall = 1;
        tick("halt", 32'h20, 0);
        halt = 0; stall = 0;
        for (int i = 0; i < 5; i++) tick("halted", 32'h20, 0);
        resume = 1;
        tick("resume", 32'h20, 1);
        resume = 0;
        tick("run24", 32'h24, 1);
        halt = 1; stall = 1;
        tick("halt2", 32'h24, 0);
        halt = 0; stall = 0; trap_valid = 1;
        tick("trap_halted", 32'h80, 1);
        trap_valid = 0;
        tick("run84", 32'h84, 1);
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
        tick("top", 32'hFFFF_FFFC, 1);
        redirect_valid = 0;
        tick("wrap", 32'h0, 1);
        ras_push = 1; ras_push_addr = 32'h900;
        tick("push9", 32'h4, 1, 0, 0, 0);
        rst = 1; ras_push_addr = 32'hA00;
        tick("rst_mid", 32'h0, 0);
        rst = 0; ras_push = 0;
        tick("boot2", 32'h0, 1);
        tick("seq2", 32'h4, 1);
        @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
